// File: rtl/pio_pkg.sv
// Shared definitions for the PIO state machine blocks: default widths and
// the fetch sequencer state encoding.
package pio_pkg;
  localparam int PIO_ADDR_W  = 4;
  localparam int PIO_INSTR_W = 8;
  localparam int PIO_DELAY_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DELAY
  } fetch_state_t;
endpackage

// File: rtl/pio_wrap_next.sv
// Sequential successor of an instruction address with wrap_top -> wrap_bottom
// looping. No window check: any address equal to wrap_top wraps.
module pio_wrap_next
  import pio_pkg::*;
#(
  parameter int ADDR_W = PIO_ADDR_W
) (
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] wrap_bottom,
  input  logic [ADDR_W-1:0] wrap_top,
  output logic [ADDR_W-1:0] nxt
);
  assign nxt = (a == wrap_top) ? wrap_bottom : a + ADDR_W'(1);
endmodule

// File: rtl/pio_fetch_unit.sv
// Instruction fetch sequencer for one PIO state machine: drives the register
// file read address and holds the current instruction for execute.
module pio_fetch_unit
  import pio_pkg::*;
#(
  parameter int ADDR_W   = PIO_ADDR_W,
  parameter int INSTR_W  = PIO_INSTR_W,
  parameter int DELAY_W  = PIO_DELAY_W,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  input  logic [ADDR_W-1:0]  wrap_bottom,
  input  logic [ADDR_W-1:0]  wrap_top,
  input  logic               stall,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_addr,
  input  logic [DELAY_W-1:0] delay_val,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [INSTR_W-1:0] rd_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               delaying
);
  // Handshake: execute takes instr on any cycle with instr_valid=1 and
  // stall=0 while running; jmp_valid/delay_val are only looked at then.
  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pc_q, pc_n, seq_next, target;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic               valid_q, valid_n;
  logic [DELAY_W-1:0] cnt, cnt_n;
  logic               consume;

  pio_wrap_next #(.ADDR_W(ADDR_W)) u_wrap_next (
    .a          (pc_q),
    .wrap_bottom(wrap_bottom),
    .wrap_top   (wrap_top),
    .nxt        (seq_next)
  );

  assign consume = valid_q & ~stall & (state == RUN);
  assign target  = jmp_valid ? jmp_addr : seq_next;
  // Reading the target on consume is what gives zero-bubble jumps and wraps.
  assign rd_addr = consume ? target : pc_q;

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    valid_n = valid_q;
    cnt_n   = cnt;
    if (restart) begin
      state_n = IDLE;
      pc_n    = wrap_bottom;
      valid_n = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            instr_n = rd_data;
            valid_n = 1'b1;
            state_n = RUN;
          end
        end
        RUN: begin
          if (consume) pc_n = target;
          if (!en) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end else if (consume) begin
            if (delay_val == '0) begin
              instr_n = rd_data;
            end else begin
              valid_n = 1'b0;
              cnt_n   = delay_val;
              state_n = DELAY;
            end
          end
        end
        DELAY: begin
          if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == DELAY_W'(1)) begin
            // pc already points at the target, so rd_addr=pc fetches it.
            instr_n = rd_data;
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt - DELAY_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      cnt     <= cnt_n;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign delaying    = (state == DELAY);
endmodule

// File: tb/tb_pio_fetch_unit.sv
// Bench for pio_fetch_unit: directed walk through looping, jumps, stalls,
// delays, enable/restart and async reset, then randomized traffic.
module tb_pio_fetch_unit;
  localparam int AW  = 4;
  localparam int IW  = 8;
  localparam int DW  = 5;
  localparam int RPC = 2;

  localparam int M_STOPPED = 0;
  localparam int M_ISSUING = 1;
  localparam int M_WAITING = 2;

  logic          clk = 1'b0;
  logic          rst, en, restart, stall, jmp_valid;
  logic [AW-1:0] wrap_bottom, wrap_top, jmp_addr, rd_addr, pc;
  logic [DW-1:0] delay_val;
  logic [IW-1:0] rd_data, instr;
  logic          instr_valid, delaying;

  logic [IW-1:0] mem [16];
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  pio_fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DELAY_W(DW), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .wrap_bottom(wrap_bottom), .wrap_top(wrap_top), .stall(stall),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .delay_val(delay_val),
    .rd_addr(rd_addr), .rd_data(rd_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .delaying(delaying)
  );

  int vectors = 0;
  int errors  = 0;
  logic check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-flow model: while issuing, the held instruction is always the
  // memory word at the model pc (memory only changes under reset).
  int            m_mode;
  logic [AW-1:0] m_pc;
  logic          m_valid;
  int            m_left;

  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a);
    if (a == wrap_top) return wrap_bottom;
    return AW'((int'(a) + 1) % 16);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_STOPPED; m_pc = AW'(RPC); m_valid = 1'b0; m_left = 0;
    end else if (restart) begin
      m_mode = M_STOPPED; m_pc = wrap_bottom; m_valid = 1'b0; m_left = 0;
    end else if (m_mode == M_STOPPED) begin
      if (en) begin m_mode = M_ISSUING; m_valid = 1'b1; end
    end else if (m_mode == M_ISSUING) begin
      if (!stall) m_pc = jmp_valid ? jmp_addr : step_addr(m_pc);
      if (!en) begin
        m_mode = M_STOPPED; m_valid = 1'b0;
      end else if (!stall && delay_val != 0) begin
        m_mode = M_WAITING; m_valid = 1'b0; m_left = int'(delay_val);
      end
    end else begin
      if (!en) begin
        m_mode = M_STOPPED; m_left = 0;
      end else if (m_left == 1) begin
        m_mode = M_ISSUING; m_valid = 1'b1; m_left = 0;
      end else begin
        m_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [AW-1:0] exp_rd;
      exp_rd = (m_mode == M_ISSUING && !stall) ? (jmp_valid ? jmp_addr : step_addr(m_pc)) : m_pc;
      check("valid", 32'(instr_valid), 32'(m_valid));
      check("pc", 32'(pc), 32'(m_pc));
      check("delaying", 32'(delaying), 32'(m_mode == M_WAITING));
      check("rd_addr", 32'(rd_addr), 32'(exp_rd));
      if (m_valid) check("instr", 32'(instr), 32'(mem[m_pc]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic v, input logic [AW-1:0] p,
                            input logic [IW-1:0] ins, input logic dl);
    check({name, "_valid"}, 32'(instr_valid), 32'(v));
    check({name, "_pc"}, 32'(pc), 32'(p));
    check({name, "_delaying"}, 32'(delaying), 32'(dl));
    if (v) check({name, "_instr"}, 32'(instr), 32'(ins));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = IW'(i + 16);
    rst = 1'b1; en = 1'b0; restart = 1'b0; stall = 1'b0; jmp_valid = 1'b0;
    jmp_addr = '0; delay_val = '0; wrap_bottom = 4'd2; wrap_top = 4'd5;
    #12;
    expect_lit("reset", 1'b0, 4'd2, 8'h00, 1'b0);
    check("reset_instr", 32'(instr), 32'h0);
    check("reset_rd_addr", 32'(rd_addr), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0; check_en = 1'b1;

    // Linear looping through the 2..5 window, one instruction per cycle.
    en = 1'b1;
    tick(); expect_lit("fetch0", 1'b1, 4'd2, 8'h12, 1'b0);
    tick(); expect_lit("lin3", 1'b1, 4'd3, 8'h13, 1'b0);
    tick(); expect_lit("lin4", 1'b1, 4'd4, 8'h14, 1'b0);
    tick(); expect_lit("lin5", 1'b1, 4'd5, 8'h15, 1'b0);
    tick(); expect_lit("wrap", 1'b1, 4'd2, 8'h12, 1'b0);
    tick(); expect_lit("lin3b", 1'b1, 4'd3, 8'h13, 1'b0);

    // Stall holds everything; a jump offered under stall is ignored.
    stall = 1'b1; jmp_valid = 1'b1; jmp_addr = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_lit("stall", 1'b1, 4'd3, 8'h13, 1'b0);
    end
    stall = 1'b0; jmp_valid = 1'b0;
    tick(); expect_lit("unstall", 1'b1, 4'd4, 8'h14, 1'b0);

    // Delay of 3 after the instruction at pc=4.
    delay_val = 5'd3;
    tick(); expect_lit("dly1", 1'b0, 4'd5, 8'h00, 1'b1);
    delay_val = 5'd0;
    tick(); expect_lit("dly2", 1'b0, 4'd5, 8'h00, 1'b1);
    tick(); expect_lit("dly3", 1'b0, 4'd5, 8'h00, 1'b1);
    tick(); expect_lit("dly_end", 1'b1, 4'd5, 8'h15, 1'b0);
    tick(); expect_lit("wrap2", 1'b1, 4'd2, 8'h12, 1'b0);
    tick(); expect_lit("lin3c", 1'b1, 4'd3, 8'h13, 1'b0);

    // Zero-bubble jump, then sequential step outside the window.
    jmp_valid = 1'b1; jmp_addr = 4'd9;
    tick(); expect_lit("jump", 1'b1, 4'd9, 8'h19, 1'b0);
    jmp_valid = 1'b0;
    tick(); expect_lit("after_jump", 1'b1, 4'd10, 8'h1a, 1'b0);

    // Enable dropped mid-delay, then restart.
    delay_val = 5'd2;
    tick(); expect_lit("dly_en", 1'b0, 4'd11, 8'h00, 1'b1);
    delay_val = 5'd0; en = 1'b0;
    tick(); expect_lit("en_off", 1'b0, 4'd11, 8'h00, 1'b0);
    tick(); expect_lit("en_off2", 1'b0, 4'd11, 8'h00, 1'b0);
    restart = 1'b1; en = 1'b1;
    tick(); expect_lit("restart", 1'b0, 4'd2, 8'h00, 1'b0);
    restart = 1'b0;
    tick(); expect_lit("refetch", 1'b1, 4'd2, 8'h12, 1'b0);

    // Asynchronous reset while running at pc=7.
    jmp_valid = 1'b1; jmp_addr = 4'd7;
    tick(); expect_lit("jump7", 1'b1, 4'd7, 8'h17, 1'b0);
    jmp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_lit("async_rst", 1'b0, 4'd2, 8'h00, 1'b0);
    check("async_rst_instr", 32'(instr), 32'h0);
    tick(); rst = 1'b0;

    // Randomized traffic, with fresh memory and windows per block.
    for (int blk = 0; blk < 3; blk++) begin
      rst = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = IW'($urandom);
      wrap_bottom = AW'($urandom_range(0, 15));
      wrap_top    = AW'($urandom_range(0, 15));
      tick();
      rst = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        en        = ($urandom_range(0, 15) != 0);
        restart   = ($urandom_range(0, 29) == 0);
        stall     = ($urandom_range(0, 3) == 0);
        jmp_valid = ($urandom_range(0, 4) == 0);
        jmp_addr  = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 7) != 0) delay_val = '0;
        else if ($urandom_range(0, 9) == 0) delay_val = 5'd31;
        else delay_val = DW'($urandom_range(1, 4));
        if ($urandom_range(0, 49) == 0) begin
          wrap_bottom = AW'($urandom_range(0, 15));
          wrap_top    = AW'($urandom_range(0, 15));
        end
        tick();
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pio_fetch_unit.md
# pio_fetch_unit

Instruction fetch sequencer for one PIO state machine. It is the read side of the 16-entry instruction register file. It drives the register file's combinational read address and holds the current instruction in a register for the execute stage. It tracks the program counter with wrap_top/wrap_bottom looping, zero-bubble jumps, post-instruction delay cycles, and enable/restart control.

## Interface
Parameters:
- ADDR_W, 4, instruction memory address width (16 entries)
- INSTR_W, 8, instruction width; matches register file data width
- DELAY_W, 5, width of the delay count (0..31 idle cycles)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  state machine enable
- restart  in  1  single-cycle pulse; PC := wrap_bottom, pipeline flushed
- wrap_bottom  in  ADDR_W  loop start address
- wrap_top  in  ADDR_W  loop end address
- stall  in  1  execute stage not accepting the current instruction
- jmp_valid  in  1  current instruction redirects flow; sampled only on consume
- jmp_addr  in  ADDR_W  jump target
- delay_val  in  DELAY_W  idle cycles after the current instruction; sampled only on consume
- rd_addr  out  ADDR_W  read address to register file (combinational)
- rd_data  in  INSTR_W  register file read data (combinational, same cycle)
- instr  out  INSTR_W  current instruction
- instr_valid  out  1  instr is valid for execute
- pc  out  ADDR_W  address of instr, or of the next fetch while instr_valid=0
- delaying  out  1  high while in DELAY

## Operation
- next(a): wrap_bottom if a == wrap_top, else (a+1) mod 2^ADDR_W. Applies even when wrap_top < wrap_bottom or pc lies outside the window.
- consume = instr_valid & ~stall & state==RUN.
- target = jmp_valid ? jmp_addr : next(pc).
- rd_addr: target when consume, else pc.
- States: IDLE, RUN, DELAY.
- IDLE: instr_valid=0.
  - If en: instr<=rd_data (rd_addr=pc), instr_valid<=1, go to RUN.
- RUN:
  - consume & delay_val==0 & en: instr<=rd_data (at target), pc<=target, stay in RUN.
  - consume & delay_val!=0: pc<=target, instr_valid<=0, cnt<=delay_val, go to DELAY.
  - ~consume: hold all state.
  - en low: go to IDLE, instr_valid<=0. If consume happens in the same cycle, pc<=target still applies. No further fetch.
- DELAY: cnt decrements each cycle.
  - When cnt==1 & en: instr<=rd_data (rd_addr=pc), instr_valid<=1, go to RUN.
  - en low: go to IDLE, remaining delay discarded, pc held.
- restart: highest priority after rst. pc<=wrap_bottom, instr_valid<=0, cnt<=0, state<=IDLE. A refetch follows on the next cycle if en.
- jmp_valid and delay_val are ignored when not consuming.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, delaying=0, state IDLE, cnt=0. rd_addr=RESET_PC.
- Fetch latency: instr is valid 1 cycle after en rises in IDLE.
- Steady state: one instruction per cycle with stall low, including across jumps and wraps (zero bubbles).
- Delay N: exactly N cycles with instr_valid=0 between consume and the next valid instruction.
- Stall: instr, pc, and instr_valid stay stable for any number of cycles.
- Reset mid-DELAY or mid-RUN: all state returns to reset values immediately (asynchronous).

## Structure
- Shared package pio_pkg holds:
  - ADDR_W, INSTR_W, DELAY_W defaults
  - state enum fetch_state_t {IDLE, RUN, DELAY}
- One sub-module, pio_wrap_next: combinational next(a) from a, wrap_bottom, wrap_top. It is reused by the future jump/condition decoder.

## Test plan
- Linear wrap: mem[i]=i+0x10, wrap_bottom=2, wrap_top=5, RESET_PC=2, en=1, stall=0 -> instr sequence 0x12,0x13,0x14,0x15,0x12,... with one instruction per cycle.
- Jump: at pc=3 assert jmp_valid with jmp_addr=9 -> next cycle pc=9, instr=0x19, no bubble. A jmp_valid presented while stall=1 is ignored.
- Delay: consume at pc=4 with delay_val=3 -> instr_valid low for exactly 3 cycles, delaying=1, then instr=0x15.
- Stall: stall=1 for 4 cycles at pc=3 -> instr=0x13 and pc=3 held. Release -> 0x14 next cycle.
- Enable/restart: en low during DELAY -> IDLE with pc held. restart pulse -> pc=wrap_bottom, instr_valid=0, then instr=mem[wrap_bottom] 1 cycle later with en=1.
- Async reset mid-RUN at pc=7 -> pc=RESET_PC, instr_valid=0, instr=0 before the next clock edge.
